// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the iterative ALU and the ALU control decoder.
// Both blocks import the ALU control code encodings from here, so each
// encoding is defined in one place only. This package also holds the FSM
// state type and small helpers that classify an operation code.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_OR   = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1100;
    localparam logic [3:0] ALU_CTZ  = 4'b1111;

    // Iterative-core states
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } alu_state_t;

    // True for the three shift operations
    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    // True for every operation that may take more than one cycle
    function automatic logic is_iterative(input logic [3:0] code);
        return is_shift(code) || (code == ALU_CTZ);
    endfunction

endpackage

// File: rtl/alu_fast_ops.sv
// alu_fast_ops
// Purely combinational single-cycle ALU operations: ADD, SUB, SLT, SLTU,
// XOR, OR and AND. Any other code, including the iterative shift and CTZ
// codes, produces 0.
//
// Ports:
//   alu_control  in   4      operation code
//   op_a         in   WIDTH  operand A
//   op_b         in   WIDTH  operand B
//   result       out  WIDTH  combinational result
module alu_fast_ops
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result
);

    // Compare results are a single bit zero-extended to the full width.
    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative
// Multi-cycle integer ALU. Logic, add/sub and compare operations complete
// in one cycle through alu_fast_ops. Shifts move one bit position per cycle,
// and CTZ shifts the operand right one bit per cycle while it counts. A
// start/busy/done handshake lets the core controller stall while an
// iterative operation runs.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active-low
//   start        in   1      request, sampled only while busy == 0
//   alu_control  in   4      operation code
//   op_a         in   WIDTH  operand A
//   op_b         in   WIDTH  operand B; op_b[SHW-1:0] is the shift amount
//   busy         out  1      iterative operation in progress
//   done         out  1      one-cycle pulse when result/zero update
//   result       out  WIDTH  registered result, held until the next done
//   zero         out  1      registered (result == 0)
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    // count needs one extra bit so that it can reach WIDTH for CTZ of zero.
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

    alu_state_t       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW:0]     count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] fast_result;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] step_value;
    logic [SHW:0]     count_inc;

    assign shamt     = op_b[SHW-1:0];
    assign count_inc = count_q + CNT_ONE;

    alu_fast_ops #(
        .WIDTH (WIDTH)
    ) u_fast_ops (
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .result      (fast_result)
    );

    // One-bit step of the latched operation. SRA copies the current MSB,
    // which is always the original sign bit of op_a. CTZ shifts right so
    // that bit 0 always holds the next bit to examine.
    always_comb begin
        step_value = work_q;
        case (op_q)
            ALU_SLL: step_value = {work_q[WIDTH-2:0], 1'b0};
            ALU_SRL: step_value = {1'b0, work_q[WIDTH-1:1]};
            ALU_SRA: step_value = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            ALU_CTZ: step_value = {1'b0, work_q[WIDTH-1:1]};
            default: step_value = work_q;
        endcase
    end

    // Next-state logic. Operations that need zero iterations (fast ops,
    // shifts by 0, CTZ with bit 0 set) finish directly from IDLE, so busy
    // never rises for them.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        count_d  = count_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!is_iterative(alu_control)) begin
                        result_d = fast_result;
                        zero_d   = (fast_result == '0);
                        done_d   = 1'b1;
                    end else if (is_shift(alu_control) && (shamt == '0)) begin
                        result_d = op_a;
                        zero_d   = (op_a == '0);
                        done_d   = 1'b1;
                    end else if ((alu_control == ALU_CTZ) && op_a[0]) begin
                        result_d = '0;
                        zero_d   = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        op_d    = alu_control;
                        work_d  = op_a;
                        count_d = is_shift(alu_control) ? {1'b0, shamt} : '0;
                    end
                end
            end

            ST_RUN: begin
                work_d = step_value;
                if (op_q == ALU_CTZ) begin
                    count_d = count_inc;
                    if (step_value[0] || (count_inc == CNT_FULL)) begin
                        result_d = {{(WIDTH-SHW-1){1'b0}}, count_inc};
                        zero_d   = (count_inc == '0);
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    // count holds the shifts still to do, including this one.
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        result_d = step_value;
                        zero_d   = (step_value == '0);
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Register update. Reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_OR;
            work_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative
// Self-checking bench for alu_iterative (WIDTH = 32). Directed steps are
// followed by randomized operations. Expected results and latencies come
// from a behavioural reference model written with plain arithmetic.
module tb_alu_iterative;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int          total;
    int          bad;
    logic [31:0] prevResult;

    alu_iterative #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result and number of extra cycles before done.
    task automatic refModel(input logic [3:0] code, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] res,
                            output int lat);
        int sh;
        sh  = int'(b[4:0]);
        lat = 0;
        case (code)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  res = a ^ b;
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_SLL: begin res = a << sh; lat = sh; end
            ALU_SRL: begin res = a >> sh; lat = sh; end
            ALU_SRA: begin res = 32'($signed(a) >>> sh); lat = sh; end
            ALU_CTZ: begin
                int n;
                n = 0;
                while (n < 32 && a[n] == 1'b0) n++;
                res = 32'(n);
                lat = n;
            end
            default:  res = 32'd0;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the current point (just after a rising edge)
    // and follow it to its done pulse. With poke set, start is pulsed with
    // random operands during the second busy cycle.
    task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input bit poke);
        logic [31:0] expRes;
        int          lat;
        int          cyc;
        refModel(code, a, b, expRes, lat);
        start       = 1'b1;
        alu_control = code;
        op_a        = a;
        op_b        = b;
        @(posedge clk); #1;
        start       = 1'b0;
        alu_control = 4'($urandom_range(15, 0));
        op_a        = $urandom;
        op_b        = $urandom;
        cyc = 1;
        while (done !== 1'b1 && cyc <= 40) begin
            if (cyc <= lat) begin
                checkOutput("busy_run", 32'(busy), 32'd1);
                checkOutput("result_hold", result, prevResult);
            end
            start = (poke && cyc == 2) ? 1'b1 : 1'b0;
            if (start) begin
                alu_control = ALU_ADD;
                op_a        = $urandom;
                op_b        = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checkOutput("latency", 32'(cyc), 32'(lat + 1));
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("result", result, expRes);
        checkOutput("zero", 32'(zero), 32'(expRes == 32'd0));
        checkOutput("busy_done", 32'(busy), 32'd0);
        prevResult = expRes;
    endtask

    initial begin
        logic [3:0] codes [13];
        total       = 0;
        bad         = 0;
        prevResult  = 32'd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        alu_control = 4'd0;
        op_a        = 32'd0;
        op_b        = 32'd0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;

        // Fast ops, back-to-back in the done cycle
        applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        applyStimulus(ALU_SUB, 32'd5, 32'd7, 1'b0);
        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Shifts
        applyStimulus(ALU_SRA, 32'h8000_0000, 32'h23, 1'b0);
        applyStimulus(ALU_SLL, 32'h1234_5678, 32'h40, 1'b0);

        // CTZ boundaries
        applyStimulus(ALU_CTZ, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(ALU_CTZ, 32'h0000_0000, 32'd0, 1'b0);
        applyStimulus(ALU_CTZ, 32'h0000_0001, 32'd0, 1'b0);

        // start during busy is ignored
        applyStimulus(ALU_SRL, 32'hF0F0_F0F0, 32'd4, 1'b1);
        @(posedge clk); #1;
        checkOutput("ignored_start_done", 32'(done), 32'd0);
        checkOutput("ignored_start_result", result, 32'h0F0F_0F0F);

        // Reset in the middle of CTZ
        start       = 1'b1;
        alu_control = ALU_CTZ;
        op_a        = 32'd0;
        op_b        = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        prevResult = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end

        // Unknown code
        applyStimulus(4'b1001, 32'h1111_1111, 32'h2222_2222, 1'b0);

        // Randomized operations
        codes = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL,
                  ALU_SRA, ALU_XOR, ALU_OR, ALU_AND, ALU_CTZ, 4'b1001,
                  4'b1110};
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = codes[$urandom_range(12, 0)];
            a = $urandom;
            b = $urandom;
            if (c == ALU_CTZ) begin
                a = a << $urandom_range(31, 0);
                if ($urandom_range(7, 0) == 0) a = 32'd0;
            end
            if ($urandom_range(9, 0) == 0) b = a;
            applyStimulus(c, a, b, ($urandom_range(3, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
